seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits (2..8).
REQ-002 SHALL have parameter PATTERN, default 4'b1011: transmitted pattern, MSB sent first.
REQ-003 SHALL have parameter GAP, default 2: idle bit-times between repeated frames (0..7).
REQ-004 SHALL have ports:
  - ck     input   1  clock; all state on rising edge.
  - rs     input   1  asynchronous reset, active-low.
  - start  input   1  request transmission; sampled only in IDLE.
  - rpt    input   4  extra frame count; frames sent = rpt+1; latched at accepted start.
  - c      output  1  serial data out, registered.
  - valid  output  1  high while c carries a pattern bit, registered.
  - busy   output  1  high from first pattern bit through last pattern bit, registered.
  - done   output  1  one-cycle pulse after last bit of last frame, registered.

Function
REQ-005 SHALL implement Moore FSM IDLE, SHIFT, GAP, DONE; all outputs registered, none combinational from inputs.
REQ-006 IDLE: c=0, valid=0, busy=0, done=0; start=1 at an edge -> SHIFT; latch rpt into frame counter; load PATTERN into shift register.
REQ-007 Latency: start sampled at edge N -> PATTERN[PAT_W-1] on c with valid=1, busy=1 in cycle after edge N; bit k (MSB-first) in cycle N+1+k.
REQ-008 SHIFT: one bit per cycle, left shift; bit counter counts 0..PAT_W-1; after bit PAT_W-1: frame counter=0 -> DONE, else GAP>0 -> GAP, else reload PATTERN and stay in SHIFT (back-to-back frames, no idle cycle).
REQ-009 GAP: c=0, valid=0, busy=1 for exactly GAP cycles; then reload PATTERN, decrement frame counter, -> SHIFT.
REQ-010 Frame counter SHALL decrement once per completed non-final frame; 4-bit, never wraps below 0.
REQ-011 DONE: done=1, busy=0, valid=0, c=0 for exactly one cycle; -> IDLE unconditionally.
REQ-012 start while in SHIFT, GAP or DONE SHALL be ignored, not queued; rpt changes after acceptance SHALL have no effect.
REQ-013 start held high continuously SHALL begin a new transmission on the first edge in IDLE after DONE (one idle cycle minimum between transmissions).
REQ-014 Illegal state encodings SHALL return to IDLE on next edge.

Reset
REQ-015 rs=0 SHALL immediately force IDLE and c=0, valid=0, busy=0, done=0, counters and shift register to 0, regardless of ck.
REQ-016 Reset asserted mid-frame SHALL abort the frame with no done pulse; after rs release, first transmission needs a new start.

Structure
REQ-017 Shared package seq_gen_pkg SHALL hold state encoding constants (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11) and the default pattern constant 4'b1011.
REQ-018 Shift register with parallel load and MSB-out SHALL be sub-module seq_gen_shreg (ports ck, rs, load, shift, din[PAT_W-1:0], dout); FSM and counters stay in seq_gen.

Verification
REQ-019 rs low then high, start pulse, rpt=0 -> c = 1,0,1,1 with valid=1 in cycles 1..4 after accepting edge; done=1 in cycle 5; busy=0 afterward.
REQ-020 rpt=2, GAP=2 -> 1011 00 1011 00 1011 on c; valid low exactly in the four gap cycles; busy continuously high 16 cycles; single done pulse.
REQ-021 rpt=1, GAP=0 -> 10111011 contiguous, valid high 8 cycles, done in cycle 9.
REQ-022 start pulsed during second bit and during DONE -> ignored; exactly one frame sent, IDLE reached.
REQ-023 rs driven low between clock edges during third bit -> c, valid, busy drop to 0 without a clock edge; no done; later start yields full 1011 frame.
REQ-024 start held high, rpt=0 -> frames 1011 separated by exactly two cycles (DONE, IDLE) each with c=0.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared definitions for the serial pattern generator.
//   state_t         - FSM state encoding (IDLE=00, SHIFT=01, GAP=10, DONE=11)
//   DEFAULT_PATTERN - pattern transmitted when the top is not overridden
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: request/serial-output bundle of the pattern generator.
//   start - request a transmission (master -> slave)
//   rpt   - extra frame count, frames sent = rpt+1 (master -> slave)
//   c     - serial data out (slave -> master)
//   valid - c carries a pattern bit (slave -> master)
//   busy  - transmission in progress, pattern and gap bits (slave -> master)
//   done  - one-cycle completion pulse (slave -> master)
interface seq_gen_if;
  logic       start;
  logic [3:0] rpt;
  logic       c;
  logic       valid;
  logic       busy;
  logic       done;

  modport master (output start, rpt, input c, valid, busy, done);
  modport slave  (input start, rpt, output c, valid, busy, done);
endinterface

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: parallel-load, MSB-out left shift register.
//   ck    - clock, rising edge
//   rs    - asynchronous reset, active-low; clears the register
//   load  - load din (has priority over shift)
//   shift - shift left by one, zero fill
//   din   - parallel load value
//   dout  - current MSB
// Zero fill means the register is all zeros once every loaded bit has been
// shifted out, so dout doubles as the idle-low serial output.
module seq_gen_shreg #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             ck,
  input  logic             rs,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             dout
);

  logic [PAT_W-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[PAT_W-2:0], 1'b0};
    end
  end

  assign dout = sr[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: repeating serial pattern generator.
//   ck  - clock, rising edge
//   rs  - asynchronous reset, active-low
//   bus - seq_gen_if slave: start/rpt in; c/valid/busy/done out (all registered)
// A start in IDLE sends PATTERN (MSB first) rpt+1 times, separated by GAP
// idle bit-times, then pulses done for one cycle and returns to IDLE.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int unsigned      GAP     = 2
) (
  input logic      ck,
  input logic      rs,
  seq_gen_if.slave bus
);

  localparam logic [2:0] BIT_LAST = 3'(PAT_W - 1);
  localparam logic [2:0] GAP_LAST = 3'((GAP == 0) ? 0 : GAP - 1);

  state_t     state, state_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [2:0] gap_cnt, gap_cnt_d;
  logic [3:0] frame_cnt, frame_cnt_d;
  logic       load, shift;
  logic       valid_q, busy_q, done_q;
  logic       sr_out;

  seq_gen_shreg #(.PAT_W(PAT_W)) u_shreg (
    .ck   (ck),
    .rs   (rs),
    .load (load),
    .shift(shift),
    .din  (PATTERN),
    .dout (sr_out)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    gap_cnt_d   = gap_cnt;
    frame_cnt_d = frame_cnt;
    load        = 1'b0;
    shift       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_SHIFT;
          load        = 1'b1;
          bit_cnt_d   = '0;
          frame_cnt_d = bus.rpt;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_d = '0;
          if (frame_cnt == 4'd0) begin
            state_d = ST_DONE;
            shift   = 1'b1;      // clears the register so c goes low
          end else if (GAP != 0) begin
            state_d   = ST_GAP;
            shift     = 1'b1;
            gap_cnt_d = '0;
          end else begin
            // Back-to-back frame: reload on the last bit, no idle cycle.
            load        = 1'b1;
            frame_cnt_d = frame_cnt - 4'd1;
          end
        end else begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt + 3'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d     = ST_SHIFT;
          load        = 1'b1;
          gap_cnt_d   = '0;
          frame_cnt_d = frame_cnt - 4'd1;  // nonzero, else GAP is never entered
        end else begin
          gap_cnt_d = gap_cnt + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the shift register contents in the same cycle.
  always_ff @(posedge ck or negedge rs) begin
    if (!rs) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      gap_cnt   <= gap_cnt_d;
      frame_cnt <= frame_cnt_d;
      valid_q   <= (state_d == ST_SHIFT);
      busy_q    <= (state_d == ST_SHIFT) || (state_d == ST_GAP);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.c     = sr_out;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: scoreboard bench for seq_gen. Two instances share clock and
// reset: dut (GAP=2) and dut0 (GAP=0). Expected per-cycle {c,valid,busy,done}
// tuples are queued when stimulus is launched and popped one per cycle.
module tb_seq_gen;

  typedef struct packed {
    logic c;
    logic valid;
    logic busy;
    logic done;
  } obs_t;

  logic ck = 1'b0;
  logic rs = 1'b0;

  seq_gen_if bus ();
  seq_gen_if bus0 ();

  seq_gen #(.GAP(2)) dut  (.ck(ck), .rs(rs), .bus(bus));
  seq_gen #(.GAP(0)) dut0 (.ck(ck), .rs(rs), .bus(bus0));

  always #5 ck = ~ck;

  int         checks = 0;
  int         errors = 0;
  obs_t       exp_q[$];
  logic [3:0] pat = 4'b1011;

  function automatic obs_t observe(input bit sel);
    if (sel) return {bus0.c, bus0.valid, bus0.busy, bus0.done};
    return {bus.c, bus.valid, bus.busy, bus.done};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) bus0.start = v;
    else     bus.start  = v;
  endtask

  task automatic set_rpt(input bit sel, input logic [3:0] v);
    if (sel) bus0.rpt = v;
    else     bus.rpt  = v;
  endtask

  // Reference model: frames MSB first, gap cycles between frames, then one
  // DONE cycle and one IDLE cycle.
  task automatic push_frames(input int rpt, input int gap);
    for (int f = 0; f <= rpt; f++) begin
      for (int k = 3; k >= 0; k--) exp_q.push_back(obs_t'({pat[k], 1'b1, 1'b1, 1'b0}));
      if (f < rpt)
        for (int g = 0; g < gap; g++) exp_q.push_back(obs_t'(4'b0010));
    end
    exp_q.push_back(obs_t'(4'b0001));
    exp_q.push_back(obs_t'(4'b0000));
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(obs_t'(4'b0000));
  endtask

  // Pulse start for one edge, then scramble rpt: it must no longer matter.
  // Returns at the falling edge of the first output cycle.
  task automatic launch(input bit sel, input logic [3:0] r);
    @(negedge ck);
    set_start(sel, 1'b1);
    set_rpt(sel, r);
    @(negedge ck);
    set_start(sel, 1'b0);
    set_rpt(sel, 4'hF);
  endtask

  // Pop and compare one record per cycle. start is raised after record s1/s2
  // and dropped one record later (or at clr); stop ends early without waiting.
  task automatic drain(input bit sel, input string name, input int s1,
                       input int s2, input int clr, input int stop);
    obs_t e, o;
    int   i;
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe(sel);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s[%0d]: c/valid/busy/done got %b expected %b", name, i, o, e);
      end
      if (i == s1 || i == s2) set_start(sel, 1'b1);
      else if (i == s1 + 1 || i == s2 + 1 || i == clr) set_start(sel, 1'b0);
      i++;
      if (i == stop) break;
      @(negedge ck);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    #12;
    for (int s = 0; s < 2; s++) begin
      o = observe(s[0]);
      checks++;
      if (o !== obs_t'(4'b0000)) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %b expected 0000", s, o);
      end
    end
    bus.start = 1'b1;  // start during reset must not be remembered
    @(negedge ck);
    bus.start = 1'b0;
    rs = 1'b1;
    push_idle(3);
    drain(1'b0, "post_reset", -10, -10, -10, -1);
    push_idle(2);
    drain(1'b1, "post_reset0", -10, -10, -10, -1);
  endtask

  task automatic test_single();
    push_frames(0, 2);
    launch(1'b0, 4'd0);
    drain(1'b0, "single", -10, -10, -10, -1);
  endtask

  task automatic test_gap();
    push_frames(2, 2);
    launch(1'b0, 4'd2);
    drain(1'b0, "gap", -10, -10, -10, -1);
  endtask

  task automatic test_back_to_back();
    push_frames(1, 0);
    launch(1'b1, 4'd1);
    drain(1'b1, "back_to_back", -10, -10, -10, -1);
  endtask

  task automatic test_ignore_start();
    push_frames(0, 2);
    push_idle(3);
    launch(1'b0, 4'd0);
    drain(1'b0, "ignore_start", 1, 4, -10, -1);  // second bit and DONE cycle
  endtask

  task automatic test_reset_mid();
    obs_t o;
    push_frames(0, 2);
    launch(1'b0, 4'd0);
    drain(1'b0, "mid_pre", -10, -10, -10, 3);    // now inside the third bit
    exp_q.delete();
    #2 rs = 1'b0;
    #1;
    o = observe(1'b0);
    checks++;
    if (o !== obs_t'(4'b0000)) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0000", o);
    end
    @(negedge ck);
    o = observe(1'b0);
    checks++;
    if (o !== obs_t'(4'b0000)) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 0000", o);
    end
    rs = 1'b1;
    push_idle(3);
    drain(1'b0, "mid_no_done", -10, -10, -10, -1);
    push_frames(0, 2);
    launch(1'b0, 4'd0);
    drain(1'b0, "mid_restart", -10, -10, -10, -1);
  endtask

  task automatic test_held_start();
    push_frames(0, 2);
    push_frames(0, 2);
    push_idle(2);
    @(negedge ck);
    bus.start = 1'b1;
    bus.rpt   = 4'd0;
    @(negedge ck);
    drain(1'b0, "held_start", -10, -10, 6, -1);  // drop start in second frame
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.rpt    = 4'd0;
    bus0.start = 1'b0;
    bus0.rpt   = 4'd0;
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_held_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
